// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit pipelined CPU.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam logic [3:0] OPC_HLT = 4'hF;
    localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        RUN,
        HALT_PEND,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/ifid_latch.sv
// One field of the IF/ID pipeline latch: write enable plus clear-to-bubble.
import cpu_pkg::*;

module ifid_latch #(
    parameter int W = DATA_W,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wen,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= CLR_VAL;
        end else if (wen) begin
            q <= clear ? CLR_VAL : d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, next-PC select, IF/ID latch and HLT wind-down FSM.
// Optional FETCH_PERF_CNT_EN adds saturating stall/bubble counters.
import cpu_pkg::*;

module fetch_stage #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter logic [DATA_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR,
    parameter logic [3:0] HALT_OPCODE = OPC_HLT
) (
    input  logic              clk,
    input  logic              rst,
    output logic [DATA_W-1:0] imem_addr_o,
    input  logic [DATA_W-1:0] imem_data_i,
    input  logic              imem_valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] branch_target_i,
    input  logic              halt_commit_i,
    output logic [DATA_W-1:0] ifid_instr_o,
    output logic [DATA_W-1:0] ifid_pc_plus2_o,
    output logic              ifid_valid_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       bubble_cnt_o,
`endif
    output logic              halted_o
);

    localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(2);

    fetch_state_t state;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc_plus2;
    logic flush_eff;
    logic accept;
    logic is_hlt;
    logic wen;
    logic clear;

    // A halted core ignores redirects entirely.
    assign flush_eff = flush_i && (state != HALTED);
    assign accept = !flush_eff && !stall_i && imem_valid_i && (state == RUN);
    assign is_hlt = imem_data_i[DATA_W-1:DATA_W-4] == HALT_OPCODE;
    assign pc_plus2 = pc + PC_STEP;
    assign wen = !stall_i || flush_eff;
    assign clear = !accept;
    assign imem_addr_o = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (flush_eff) begin
            pc <= branch_target_i;
        end else if (accept) begin
            pc <= pc_plus2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            halted_o <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (accept && is_hlt) begin
                        state <= HALT_PEND;
                    end
                end
                HALT_PEND: begin
                    if (flush_eff) begin
                        state <= RUN;
                    end else if (halt_commit_i) begin
                        state <= HALTED;
                        halted_o <= 1'b1;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    ifid_latch #(.W(DATA_W), .CLR_VAL(NOP_INSTR)) u_instr (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen),
        .clear (clear),
        .d     (imem_data_i),
        .q     (ifid_instr_o)
    );

    ifid_latch #(.W(DATA_W), .CLR_VAL('0)) u_pc_plus2 (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen),
        .clear (clear),
        .d     (pc_plus2),
        .q     (ifid_pc_plus2_o)
    );

    ifid_latch #(.W(1), .CLR_VAL(1'b0)) u_valid (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen),
        .clear (clear),
        .d     (1'b1),
        .q     (ifid_valid_o)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (stall_i && !flush_i && stall_cnt_o != '1) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (wen && clear && bubble_cnt_o != '1) begin
                bubble_cnt_o <= bubble_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage against a rule-level model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_data = '0;
    logic        imem_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] target = '0;
    logic        commit = 1'b0;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pp2;
    logic        ifid_valid;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
`endif

    int tests = 0;
    int fails = 0;

    // Model state: 0 running, 1 waiting for HLT commit, 2 halted.
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_pp2;
    logic        m_valid;
    int          m_mode;
    longint      m_scnt;
    longint      m_bcnt;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr_o     (imem_addr),
        .imem_data_i     (imem_data),
        .imem_valid_i    (imem_valid),
        .stall_i         (stall),
        .flush_i         (flush),
        .branch_target_i (target),
        .halt_commit_i   (commit),
        .ifid_instr_o    (ifid_instr),
        .ifid_pc_plus2_o (ifid_pp2),
        .ifid_valid_o    (ifid_valid),
`ifdef FETCH_PERF_CNT_EN
        .stall_cnt_o     (stall_cnt),
        .bubble_cnt_o    (bubble_cnt),
`endif
        .halted_o        (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_bubble();
        m_instr = 16'h0000;
        m_valid = 1'b0;
        m_bcnt++;
    endtask

    task automatic model(input bit r, input bit s, input bit f,
                         input logic [15:0] t, input bit v,
                         input logic [15:0] d, input bit c);
        int old_mode;
        bit redirect;
        if (r) begin
            m_pc = 16'h0000;
            m_instr = 16'h0000;
            m_pp2 = 16'h0000;
            m_valid = 1'b0;
            m_mode = 0;
            m_scnt = 0;
            m_bcnt = 0;
            return;
        end
        old_mode = m_mode;
        redirect = f && (old_mode != 2);
        if (s && !f) m_scnt++;
        if (redirect) begin
            m_pc = t;
            model_bubble();
            if (old_mode == 1) m_mode = 0;
        end else if (s) begin
            // everything frozen
        end else if (old_mode == 0 && v) begin
            m_pc = 16'((32'(m_pc) + 2) % 65536);
            m_instr = d;
            m_pp2 = m_pc;
            m_valid = 1'b1;
            if (d[15:12] == 4'hF) m_mode = 1;
        end else begin
            model_bubble();
        end
        if (!redirect && old_mode == 1 && c) m_mode = 2;
    endtask

    task automatic step(input bit r, input bit s, input bit f,
                        input logic [15:0] t, input bit v,
                        input logic [15:0] d, input bit c);
        rst = r;
        stall = s;
        flush = f;
        target = t;
        imem_valid = v;
        imem_data = d;
        commit = c;
        #1;
        if (!r) check("imem_addr", 32'(imem_addr), 32'(m_pc));
        @(posedge clk);
        model(r, s, f, t, v, d, c);
        #1;
        check("ifid_valid", 32'(ifid_valid), 32'(m_valid));
        check("ifid_instr", 32'(ifid_instr), 32'(m_instr));
        if (m_valid || r) check("ifid_pc_plus2", 32'(ifid_pp2), 32'(m_pp2));
        check("halted", 32'(halted), 32'(m_mode == 2));
        check("pc", 32'(imem_addr), 32'(m_pc));
    endtask

    initial begin
        bit rr, ss, ff, vv, cc;
        logic [15:0] dd;
        m_pc = '0;
        m_instr = '0;
        m_pp2 = '0;
        m_valid = 1'b0;
        m_mode = 0;
        m_scnt = 0;
        m_bcnt = 0;
        #2;
        step(1, 0, 0, 16'h0, 0, 16'h0, 0);
        check("reset_addr", 32'(imem_addr), 32'h0);
        check("reset_pp2", 32'(ifid_pp2), 32'h0);
        step(0, 0, 0, 16'h0, 1, 16'h1234, 0);
        check("first_instr", 32'(ifid_instr), 32'h1234);
        check("first_pp2", 32'(ifid_pp2), 32'h2);
        step(0, 0, 0, 16'h0, 1, 16'h2345, 0);
        check("second_pp2", 32'(ifid_pp2), 32'h4);
        step(0, 0, 0, 16'h0, 1, 16'h3456, 0);
        step(0, 1, 0, 16'h0, 1, 16'h7777, 0);
        step(0, 1, 0, 16'h0, 1, 16'h7777, 0);
        check("stall_hold", 32'(ifid_instr), 32'h3456);
        step(0, 0, 0, 16'h0, 1, 16'h4567, 0);
        check("resume", 32'(ifid_pp2), 32'h8);
        step(0, 1, 1, 16'h0040, 1, 16'h5555, 0);
        check("flush_addr", 32'(imem_addr), 32'h40);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 0, 16'h9999, 0);
        step(0, 0, 0, 16'h0, 1, 16'h1111, 0);
        check("after_wait", 32'(ifid_pp2), 32'h42);
        step(0, 0, 0, 16'h0, 1, 16'hF000, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 1, 16'h2222, 0);
        check("halt_pc", 32'(imem_addr), 32'h44);
        step(0, 0, 0, 16'h0, 1, 16'h2222, 1);
        check("halted_set", 32'(halted), 32'h1);
        step(0, 0, 1, 16'h0100, 1, 16'h2222, 0);
        check("halted_flush", 32'(imem_addr), 32'h44);
        step(1, 0, 0, 16'h0, 0, 16'h0, 0);
        check("halt_cleared", 32'(halted), 32'h0);
        step(0, 0, 0, 16'h0, 1, 16'hF123, 0);
        step(0, 0, 1, 16'hFFFE, 0, 16'h0, 1);
        check("pend_flush", 32'(halted), 32'h0);
        step(0, 0, 0, 16'h0, 1, 16'h1357, 0);
        check("wrap_pc", 32'(imem_addr), 32'h0);
        check("wrap_pp2", 32'(ifid_pp2), 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("stall_cnt", stall_cnt, 32'(m_scnt));
        check("bubble_cnt", bubble_cnt, 32'(m_bcnt));
`endif
        for (int i = 0; i < 800; i++) begin
            rr = ($urandom % 60) == 0 || (m_mode == 2 && ($urandom % 8) == 0);
            ss = ($urandom % 5) == 0;
            ff = ($urandom % 12) == 0;
            vv = ($urandom % 4) != 0;
            cc = ($urandom % 4) == 0;
            dd = 16'($urandom);
            step(rr, ss, ff, 16'($urandom) & 16'hFFFE, vv, dd, cc);
        end
`ifdef FETCH_PERF_CNT_EN
        check("stall_cnt_rand", stall_cnt, 32'(m_scnt));
        check("bubble_cnt_rand", bubble_cnt, 32'(m_bcnt));
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit pipelined CPU. Owns the PC register, the next-PC selection and the IF/ID pipeline latch.
- Its outputs drive the decode stage directly, in place of the discrete IF/ID pipeline-register flops.
- Handles load-use stalls, branch flushes, a variable-latency instruction memory and the HLT wind-down state machine.

Parameters:
- DATA_W, 16, width of PC and instruction.
- RESET_PC, 16'h0000, PC value after reset.
- NOP_INSTR, 16'h0000, encoding injected as a bubble.
- HALT_OPCODE, 4'hF, value of instr[15:12] that marks HLT.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- imem_addr_o  out  DATA_W  fetch address; equals current PC (combinational).
- imem_data_i  in  DATA_W  instruction returned by memory.
- imem_valid_i  in  1  imem_data_i is valid for imem_addr_o this cycle.
- stall_i  in  1  load-use stall from hazard unit; freeze PC and IF/ID.
- flush_i  in  1  branch taken, resolved downstream; redirect and squash.
- branch_target_i  in  DATA_W  redirect PC; used only when flush_i=1.
- halt_commit_i  in  1  HLT reached writeback.
- ifid_instr_o  out  DATA_W  latched instruction.
- ifid_pc_plus2_o  out  DATA_W  latched PC+2 of that instruction.
- ifid_valid_o  out  1  latched instruction is real (0 means bubble).
- halted_o  out  1  processor halted.

Behaviour:
- Reset (clk edge with rst=1) values:
  - PC=RESET_PC.
  - ifid_instr_o=NOP_INSTR, ifid_pc_plus2_o=0, ifid_valid_o=0.
  - FSM=RUN, halted_o=0.
- Priority per cycle: rst > flush_i > stall_i > (imem_valid_i and FSM==RUN) > bubble.
- flush_i=1:
  - PC<=branch_target_i.
  - IF/ID loads NOP_INSTR with valid=0.
  - If FSM==HALT_PEND, FSM<=RUN (the HLT was on the wrong path).
  - Ignored entirely when FSM==HALTED.
- stall_i=1 (no flush): PC and all IF/ID outputs hold their values.
- Normal fetch (imem_valid_i=1, FSM==RUN, no stall/flush):
  - PC<=PC+2; wraps modulo 2^DATA_W, so 16'hFFFE goes to 16'h0000.
  - IF/ID loads imem_data_i, PC+2 and valid=1.
- Memory wait (imem_valid_i=0, no stall/flush, FSM==RUN): PC holds; IF/ID loads a bubble (NOP_INSTR, valid=0).
- Latency: an instruction appears on the IF/ID outputs one cycle after the cycle in which imem_valid_i=1 was accepted.
- FSM states: RUN, HALT_PEND, HALTED.
  - RUN -> HALT_PEND when an accepted fetch has imem_data_i[15:12]==HALT_OPCODE. PC still advances to HLT address+2 that cycle.
  - HALT_PEND: PC frozen; IF/ID loads a bubble every cycle (stall_i still holds it).
  - HALT_PEND -> RUN on flush_i.
  - HALT_PEND -> HALTED on halt_commit_i. If flush_i and halt_commit_i assert together, flush wins.
  - HALTED: terminal until rst. PC frozen, bubbles, halted_o=1 (registered, asserted the cycle after the transition).
- Reset mid-operation (including mid memory wait): all state returns to its reset values next edge. Any outstanding memory response is ignored through imem_valid_i gating by the state.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds output ports stall_cnt_o[31:0] and bubble_cnt_o[31:0]:
  - stall_cnt_o increments each cycle stall_i=1 and flush_i=0.
  - bubble_cnt_o increments each cycle IF/ID loads a bubble.
  - Both saturate at 32'hFFFFFFFF and clear on rst.
- When undefined, neither the ports nor the logic exist.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch_state_t enum (RUN, HALT_PEND, HALTED).
  - OPC_HLT constant (4'hF).
  - NOP_INSTR constant.
  - DATA_W.
- One sub-module is natural: ifid_latch, a DATA_W-wide register with wen/clear, instantiated for the instruction and PC+2 fields and for the valid bit (width 1). wen=~stall_i|flush_i; clear selects the bubble value.

Test Plan:
- Reset, then imem_valid_i=1 with data 16'h1234, 16'h2345 -> imem_addr_o 0,2,4; IF/ID shows 16'h1234/pc_plus2 2, then 16'h2345/4, valid=1.
- stall_i high for 2 cycles mid-stream -> PC and IF/ID unchanged for both cycles, resume with no loss or duplication.
- flush_i=1 with target 16'h0040 while stall_i=1 -> next imem_addr_o=16'h0040, ifid_valid_o=0.
- imem_valid_i low for 3 cycles -> PC held, 3 bubbles (valid=0), then the fetch completes normally.
- Fetch 16'hF000 -> PC frozen at HLT address+2, bubbles; halt_commit_i -> halted_o=1 next cycle; later flush_i ignored; rst clears halted_o.
- PC=16'hFFFE fetch -> PC wraps to 16'h0000 and ifid_pc_plus2_o=16'h0000. With FETCH_PERF_CNT_EN defined, check stall_cnt_o/bubble_cnt_o against the counts above.
